// File: rtl/mat_mul_pkg.sv
// Shared definitions for mat_mul_mac: controller state encoding and a
// constant-evaluable ceiling-log2 used for widths.
package mat_mul_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_MAC,
    ST_OUT
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/mat_mul_mac_mac_signed.sv
// Signed multiply-accumulate slice: clr zeroes the accumulator and wins over
// en; en adds one full-precision product per cycle.
module mac_signed #(
  parameter int unsigned DW = 5,
  parameter int unsigned AW = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc_d;
  logic signed [AW-1:0]   acc_q;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + AW'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/mat_mul_mac.sv
// Streaming M x K by K x N signed matrix multiplier with a single MAC slice.
// Optional macro MAT_MUL_MAC_SAT_EN clamps results to OW bits instead of wrapping.
module mat_mul_mac
  import mat_mul_pkg::*;
#(
  parameter int unsigned DW = 5,
  parameter int unsigned M  = 4,
  parameter int unsigned K  = 4,
  parameter int unsigned N  = 2,
  parameter int unsigned OW = 2 * DW + clog2(K)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic signed [OW-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_last,
  output logic                 busy
);

  localparam int unsigned AW = 2 * DW + clog2(K);
  localparam int unsigned NA = M * K;
  localparam int unsigned NT = NA + K * N;
  localparam int unsigned LW = clog2(NT) + 1;
  localparam int unsigned KW = clog2(K) + 1;
  localparam int unsigned IW = clog2(M) + 1;
  localparam int unsigned JW = clog2(N) + 1;

  state_e               state_d, state_q;
  logic signed [DW-1:0] mem_d [NT];
  logic signed [DW-1:0] mem_q [NT];
  logic [LW-1:0]        ld_cnt_d, ld_cnt_q;
  logic [KW-1:0]        k_cnt_d, k_cnt_q;
  logic [IW-1:0]        i_cnt_d, i_cnt_q;
  logic [JW-1:0]        j_cnt_d, j_cnt_q;
  logic                 din_ready_d, din_ready_q;
  logic                 dout_valid_d, dout_valid_q;
  logic                 dout_last_d, dout_last_q;
  logic                 busy_d, busy_q;
  logic                 mac_clr, mac_en;
  logic [LW-1:0]        a_idx, b_idx;
  logic signed [AW-1:0] acc;
  logic                 din_acc, dout_acc;

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    ld_cnt_d     = ld_cnt_q;
    k_cnt_d      = k_cnt_q;
    i_cnt_d      = i_cnt_q;
    j_cnt_d      = j_cnt_q;
    din_ready_d  = din_ready_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    busy_d       = busy_q;
    mac_clr      = 1'b0;
    mac_en       = 1'b0;
    din_acc      = din_valid && din_ready_q;
    dout_acc     = dout_valid_q && dout_ready;
    a_idx        = LW'(i_cnt_q * K + k_cnt_q);
    b_idx        = LW'(NA + k_cnt_q * N + j_cnt_q);

    unique case (state_q)
      ST_LOAD: begin
        if (din_acc) begin
          mem_d[ld_cnt_q] = din;
          if (ld_cnt_q == LW'(NT - 1)) begin
            ld_cnt_d    = '0;
            k_cnt_d     = '0;
            mac_clr     = 1'b1;
            din_ready_d = 1'b0;
            busy_d      = 1'b1;
            state_d     = ST_MAC;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (k_cnt_q == KW'(K - 1)) begin
          k_cnt_d      = '0;
          dout_valid_d = 1'b1;
          dout_last_d  = (i_cnt_q == IW'(M - 1)) && (j_cnt_q == JW'(N - 1));
          state_d      = ST_OUT;
        end else begin
          k_cnt_d = k_cnt_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (dout_acc) begin
          dout_valid_d = 1'b0;
          dout_last_d  = 1'b0;
          if (dout_last_q) begin
            i_cnt_d     = '0;
            j_cnt_d     = '0;
            din_ready_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_LOAD;
          end else begin
            mac_clr = 1'b1;
            state_d = ST_MAC;
            if (j_cnt_q == JW'(N - 1)) begin
              j_cnt_d = '0;
              i_cnt_d = i_cnt_q + 1'b1;
            end else begin
              j_cnt_d = j_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      mem_q        <= '{default: '0};
      ld_cnt_q     <= '0;
      k_cnt_q      <= '0;
      i_cnt_q      <= '0;
      j_cnt_q      <= '0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      ld_cnt_q     <= ld_cnt_d;
      k_cnt_q      <= k_cnt_d;
      i_cnt_q      <= i_cnt_d;
      j_cnt_q      <= j_cnt_d;
      din_ready_q  <= din_ready_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      busy_q       <= busy_d;
    end
  end

  mac_signed #(
    .DW(DW),
    .AW(AW)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(mac_clr),
    .en (mac_en),
    .a  (mem_q[a_idx]),
    .b  (mem_q[b_idx]),
    .acc(acc)
  );

  // The accumulator is frozen in OUT, so dout can be formed from it directly.
`ifdef MAT_MUL_MAC_SAT_EN
  localparam int unsigned CW = ((AW > OW) ? AW : OW) + 1;
  localparam logic signed [CW-1:0] SAT_HI = (CW'(1) <<< (OW - 1)) - CW'(1);
  localparam logic signed [CW-1:0] SAT_LO = -SAT_HI - CW'(1);
  logic signed [CW-1:0] acc_x;
  logic signed [CW-1:0] acc_sat;

  always_comb begin
    acc_x = CW'(acc);
    if (acc_x > SAT_HI)      acc_sat = SAT_HI;
    else if (acc_x < SAT_LO) acc_sat = SAT_LO;
    else                     acc_sat = acc_x;
    dout = dout_valid_q ? OW'(acc_sat) : '0;
  end
`else
  always_comb begin
    dout = dout_valid_q ? OW'(acc) : '0;
  end
`endif

  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mat_mul_mac.sv
// Directed bench for mat_mul_mac: a default-width DUT and an OW=10 DUT share stimulus.
module tb_mat_mul_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [4:0] din = '0;
  logic din_valid = 1'b0;
  logic dout_ready = 1'b1;
  logic din_ready, dout_valid, dout_last, busy;
  logic signed [11:0] dout;
  logic din_ready10, dout_valid10, dout_last10, busy10;
  logic signed [9:0] dout10;

  int checks = 0;
  int errors = 0;
  int idle_bad = 0;

  typedef struct packed {
    logic [15:0][4:0] a;
    logic [7:0][4:0]  b;
    logic [7:0][11:0] exp;
    logic [7:0][9:0]  exp10;
  } vec_t;
  vec_t tbl [3];

  always #5 clk = ~clk;

  mat_mul_mac dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy)
  );

  mat_mul_mac #(.DW(5), .M(4), .K(4), .N(2), .OW(10)) dut10 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready10),
    .dout(dout10), .dout_valid(dout_valid10), .dout_ready(dout_ready),
    .dout_last(dout_last10), .busy(busy10)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic signed [4:0] v);
    int n;
    n = 0;
    din = v;
    din_valid = 1'b1;
    while (!din_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("din_ready_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic load_pair(input int v, input bit hold);
    for (int i = 0; i < 16; i++) send($signed(tbl[v].a[i]));
    for (int i = 0; i < 8; i++) send($signed(tbl[v].b[i]));
    if (hold) din = 5'sd7;
    else din_valid = 1'b0;
  endtask

  task automatic collect(input int v, input int stall_idx, input bit chk_idle);
    int lat;
    int held;
    int stall_bad;
    for (int r = 0; r < 8; r++) begin
      lat = 0;
      while (!dout_valid && lat < 50) begin
        if (chk_idle && din_ready) idle_bad++;
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("latency[%0d]", r), lat, 4);
      if (r == stall_idx) begin
        dout_ready = 1'b0;
        held = dout;
        stall_bad = 0;
        for (int c = 0; c < 5; c++) begin
          @(posedge clk); #1;
          if (!dout_valid || int'(dout) != held || dout_last) stall_bad++;
        end
        chk("stall_hold", stall_bad, 0);
        dout_ready = 1'b1;
      end
      chk($sformatf("v%0d dout[%0d]", v, r), dout, $signed(tbl[v].exp[r]));
      chk($sformatf("v%0d dout10[%0d]", v, r), dout10, $signed(tbl[v].exp10[r]));
      chk($sformatf("v%0d last[%0d]", v, r), dout_last, (r == 7) ? 1 : 0);
      if (chk_idle && din_ready) idle_bad++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input int v, input int stall_idx);
    load_pair(v, 1'b0);
    collect(v, stall_idx, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " din_ready"}, din_ready, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " dout_valid"}, dout_valid, 0);
    chk({tag, " dout_last"}, dout_last, 0);
    chk({tag, " dout"}, dout, 0);
  endtask

  initial begin
    // A all ones, B = 1..8 row-major: each row gives column sums 16, 20
    for (int i = 0; i < 16; i++) tbl[0].a[i] = 5'd1;
    for (int i = 0; i < 8; i++) tbl[0].b[i] = 5'(i + 1);
    for (int i = 0; i < 8; i++) tbl[0].exp[i] = (i % 2 == 0) ? 12'd16 : 12'd20;
    for (int i = 0; i < 8; i++) tbl[0].exp10[i] = (i % 2 == 0) ? 10'd16 : 10'd20;
    // All -16: 4 * 256 = 1024; 10-bit view clamps to 511 or wraps to 0
    for (int i = 0; i < 16; i++) tbl[1].a[i] = 5'b10000;
    for (int i = 0; i < 8; i++) tbl[1].b[i] = 5'b10000;
    for (int i = 0; i < 8; i++) tbl[1].exp[i] = 12'd1024;
`ifdef MAT_MUL_MAC_SAT_EN
    for (int i = 0; i < 8; i++) tbl[1].exp10[i] = 10'd511;
`else
    for (int i = 0; i < 8; i++) tbl[1].exp10[i] = 10'd0;
`endif
    // Identity times B reproduces B
    for (int i = 0; i < 16; i++) tbl[2].a[i] = (i / 4 == i % 4) ? 5'd1 : 5'd0;
    tbl[2].b[0] = 5'b10000; tbl[2].b[1] = 5'd15;
    tbl[2].b[2] = 5'd0;     tbl[2].b[3] = 5'b11111;
    tbl[2].b[4] = 5'd5;     tbl[2].b[5] = 5'b11011;
    tbl[2].b[6] = 5'd15;    tbl[2].b[7] = 5'b10000;
    for (int i = 0; i < 8; i++) begin
      tbl[2].exp[i]   = 12'($signed(tbl[2].b[i]));
      tbl[2].exp10[i] = 10'($signed(tbl[2].b[i]));
    end

    @(posedge clk); #1;
    chk_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 3; v++) run_vec(v, -1);

    run_vec(0, 2);

    for (int i = 0; i < 10; i++) send($signed(tbl[0].a[i]));
    din_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_reset_state("midload_rst");
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(0, -1);

    idle_bad = 0;
    load_pair(0, 1'b1);
    collect(0, -1, 1'b1);
    chk("b2b din_ready low while busy", idle_bad, 0);
    chk("b2b din_ready after last", din_ready, 1);
    load_pair(2, 1'b0);
    collect(2, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
